// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared FSM encoding and requester indices for dmem_arbiter
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-way round-robin arbiter with one-hot grant
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o  = req_i;
        last_d = last_q;
        // On a tie the requester that did not win last time goes first
        if (req_i == 2'b11) begin
            gnt_o = (last_q == REQ_LDR) ? 2'b01 : 2'b10;
        end
        if (en_i && (req_i != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= REQ_LDR;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data-memory arbiter, fixed 3-cycle transactions
// Optional address checking enabled by defining DMEM_ARB_CHK_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int WORDS = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] a0,
    input  logic [AW-1:0] a1,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rd0,
    output logic [DW-1:0] rd1,
    output logic          err0,
    output logic          err1,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

`ifdef DMEM_ARB_CHK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    localparam logic [AW-1:0] WORDS_A = AW'(WORDS);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [DW-1:0] rd0_q, rd0_d;
    logic [DW-1:0] rd1_q, rd1_d;
    logic [1:0]    gnt;
    logic [AW-1:0] sel_a;
    logic          addr_bad;

    rr_arb2 u_rr (
        .clk   (clk),
        .reset (reset),
        .req_i ({req1, req0}),
        .en_i  (state_q == IDLE),
        .gnt_o (gnt)
    );

    assign sel_a    = gnt[1] ? a1 : a0;
    assign addr_bad = (sel_a[1:0] != 2'b00) || ({2'b00, sel_a[AW-1:2]} >= WORDS_A);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        err_d   = err_q;
        a_d     = a_q;
        wd_d    = wd_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    state_d = ACCESS;
                    owner_d = gnt[1];
                    we_d    = gnt[1] ? we1 : we0;
                    a_d     = sel_a;
                    wd_d    = gnt[1] ? wd1 : wd0;
                    err_d   = CHK_EN & addr_bad;
                end
            end
            ACCESS: begin
                state_d = RESP;
                // Errored accesses leave the read registers untouched
                if (!we_q && !err_q) begin
                    if (owner_q == REQ_LDR) rd1_d = mem_rd;
                    else                    rd0_d = mem_rd;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= REQ_CPU;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            a_q     <= '0;
            wd_q    <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            err_q   <= err_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    // Reset gates the strobe combinationally so a write in flight never commits
    assign mem_we = (state_q == ACCESS) && we_q && !err_q && !reset;
    assign mem_a  = a_q;
    assign mem_wd = wd_q;
    assign ack0   = (state_q == RESP) && (owner_q == REQ_CPU);
    assign ack1   = (state_q == RESP) && (owner_q == REQ_LDR);
    assign err0   = ack0 && err_q;
    assign err1   = ack1 && err_q;
    assign rd0    = rd0_q;
    assign rd1    = rd1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] a0, a1, wd0, wd1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rd0, rd1;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem [64] = '{default: 32'h0};

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[7:2]] <= mem_wd;
    end
    assign mem_rd = mem[mem_a[7:2]];

    dmem_arbiter #(.AW(32), .DW(32), .WORDS(64)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .we0    (we0),
        .we1    (we1),
        .a0     (a0),
        .a1     (a1),
        .wd0    (wd0),
        .wd1    (wd1),
        .ack0   (ack0),
        .ack1   (ack1),
        .rd0    (rd0),
        .rd1    (rd1),
        .err0   (err0),
        .err1   (err1),
        .mem_we (mem_we),
        .mem_a  (mem_a),
        .mem_wd (mem_wd),
        .mem_rd (mem_rd)
    );

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd0_e;
        logic [31:0] rd1_e;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input bit port, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd0_e, input logic [31:0] rd1_e, input bit err_e,
                       input string nm);
        if (port) begin
            req1 = 1'b1; we1 = we; a1 = a; wd1 = wd;
        end else begin
            req0 = 1'b1; we0 = we; a0 = a; wd0 = wd;
        end
        step();
        chk({nm, "_acc_we"}, mem_we, we & ~err_e);
        chk({nm, "_acc_a"}, mem_a, a);
        chk({nm, "_acc_ack"}, {ack1, ack0}, 2'b00);
        step();
        chk({nm, "_ack"}, {ack1, ack0}, port ? 2'b10 : 2'b01);
        chk({nm, "_err"}, {err1, err0}, port ? {err_e, 1'b0} : {1'b0, err_e});
        chk({nm, "_rd0"}, rd0, rd0_e);
        chk({nm, "_rd1"}, rd1, rd1_e);
        chk({nm, "_resp_we"}, mem_we, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        step();
        chk({nm, "_idle_ack"}, {ack1, ack0}, 2'b00);
    endtask

    initial begin
        int nack;
        int prev;
        vecs[0] = '{1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 32'h0,        32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h08, 32'h0,        32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 32'h10, 32'hCAFEF00D, 32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hCAFEF00D, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b1, 32'hFC, 32'h0BADF00D, 32'hCAFEF00D, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 1'b0, 32'hFC, 32'h0,        32'hCAFEF00D, 32'h0BADF00D};
        vecs[6] = '{1'b1, 1'b0, 32'h00, 32'h0,        32'hCAFEF00D, 32'h0};

        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        a0 = 0; a1 = 0; wd0 = 0; wd1 = 0;
        repeat (3) step();
        chk("rst_ack", {ack1, ack0}, 2'b00);
        chk("rst_err", {err1, err0}, 2'b00);
        chk("rst_rd", {rd1, rd0}, 64'h0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            txn(vecs[i].port, vecs[i].we, vecs[i].a, vecs[i].wd,
                vecs[i].rd0_e, vecs[i].rd1_e, 1'b0, $sformatf("vec%0d", i));
        end
        chk("mem_word2", mem[2], 32'hDEADBEEF);
        chk("mem_word4", mem[4], 32'hCAFEF00D);
        chk("mem_word63", mem[63], 32'h0BADF00D);
        chk("hold_mem_a", mem_a, 32'h00);

        // both requesters held high: strict alternation starting with requester 0
        req0 = 1; we0 = 0; a0 = 32'h08;
        req1 = 1; we1 = 0; a1 = 32'h10;
        nack = 0;
        prev = 0;
        for (int c = 1; c <= 16 && nack < 4; c++) begin
            step();
            if (ack0 || ack1) begin
                if (nack == 0) chk("tie_first_lat", c, 2);
                else           chk("tie_spacing", c - prev, 3);
                chk("tie_owner", {ack1, ack0}, (nack % 2) ? 2'b10 : 2'b01);
                if (nack % 2) chk("tie_rd1", rd1, 32'hCAFEF00D);
                else          chk("tie_rd0", rd0, 32'hDEADBEEF);
                prev = c;
                nack++;
            end
        end
        chk("tie_count", nack, 4);
        req0 = 0; req1 = 0;
        step();

        // late requester waits for the running transaction
        req0 = 1; we0 = 1; a0 = 32'h20; wd0 = 32'h11112222;
        step();
        req1 = 1; we1 = 0; a1 = 32'h20;
        chk("late_acc_ack", {ack1, ack0}, 2'b00);
        step();
        chk("late_ack0", {ack1, ack0}, 2'b01);
        req0 = 0;
        step();
        chk("late_idle", {ack1, ack0}, 2'b00);
        step();
        chk("late_acc1_a", mem_a, 32'h20);
        chk("late_acc1_ack", {ack1, ack0}, 2'b00);
        step();
        chk("late_ack1", {ack1, ack0}, 2'b10);
        chk("late_rd1", rd1, 32'h11112222);
        req1 = 0;
        step();

        // reset in the ACCESS cycle kills the write
        req0 = 1; we0 = 1; a0 = 32'h04; wd0 = 32'h12345678;
        step();
        reset = 1; req0 = 0;
        #1;
        chk("rstacc_mem_we", mem_we, 1'b0);
        step();
        chk("rstacc_state", u_dut.state_q, 2'd0);
        chk("rstacc_ack", {ack1, ack0}, 2'b00);
        reset = 0;
        step();
        chk("rstacc_ack2", {ack1, ack0}, 2'b00);
        chk("rstacc_word1", mem[1], 32'h0);
        chk("rstacc_rd", {rd1, rd0}, 64'h0);

`ifdef DMEM_ARB_CHK_EN
        txn(1'b0, 1'b1, 32'h102, 32'hAAAA5555, 32'h0, 32'h0, 1'b1, "chk_misal");
        txn(1'b0, 1'b1, 32'h100, 32'h5555AAAA, 32'h0, 32'h0, 1'b1, "chk_range");
        chk("chk_word0", mem[0], 32'h0);
`else
        txn(1'b0, 1'b0, 32'h20, 32'h0, 32'h11112222, 32'h0, 1'b0, "noerr_rd");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
